traffic_lights_fsm: RTL and testbench



---
 rtl/traffic_lights_fsm_pkg.sv | 60 ++++++
 rtl/traffic_lights_fsm_lamp_decode.sv | 42 ++++
 rtl/traffic_lights_fsm.sv | 83 ++++++++
 tb/tb_traffic_lights_fsm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/traffic_lights_fsm_pkg.sv
// Shared definitions for the four-way signal controller: state codes, lamp bit map, lamp patterns.
// Lamp patterns are built from the bit map so the two can never drift apart.
package traffic_lights_fsm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t N_ST  = 4'd0;
    localparam state_t N_RT  = 4'd1;
    localparam state_t N_YEL = 4'd2;
    localparam state_t E_ST  = 4'd3;
    localparam state_t E_RT  = 4'd4;
    localparam state_t E_YEL = 4'd5;
    localparam state_t S_ST  = 4'd6;
    localparam state_t S_RT  = 4'd7;
    localparam state_t S_YEL = 4'd8;
    localparam state_t W_ST  = 4'd9;
    localparam state_t W_RT  = 4'd10;
    localparam state_t W_YEL = 4'd11;
    localparam state_t PED   = 4'd12;

    localparam int BIT_ST_RED  = 0;
    localparam int BIT_RT_RED  = 1;
    localparam int BIT_YEL     = 2;
    localparam int BIT_ST_GRN  = 3;
    localparam int BIT_RT_GRN  = 4;
    localparam int BIT_LT_GRN  = 5;
    localparam int BIT_PED_RED = 6;
    localparam int BIT_PED_GRN = 7;

    localparam logic [7:0] LAMP_ACT_ST  = 8'((1 << BIT_ST_GRN) | (1 << BIT_LT_GRN) |
                                             (1 << BIT_RT_RED) | (1 << BIT_PED_RED));
    localparam logic [7:0] LAMP_ACT_RT  = 8'((1 << BIT_ST_RED) | (1 << BIT_RT_GRN) |
                                             (1 << BIT_LT_GRN) | (1 << BIT_PED_RED));
    localparam logic [7:0] LAMP_ACT_YEL = 8'((1 << BIT_YEL) | (1 << BIT_RT_RED) |
                                             (1 << BIT_PED_RED));
    localparam logic [7:0] LAMP_IDLE    = 8'((1 << BIT_ST_RED) | (1 << BIT_RT_RED) |
                                             (1 << BIT_PED_RED));
    localparam logic [7:0] LAMP_PED     = 8'((1 << BIT_ST_RED) | (1 << BIT_RT_RED) |
                                             (1 << BIT_PED_GRN));

    // Successor of each phase once its dwell expires; unknown codes fall back to North straight.
    function automatic state_t next_state(input state_t s);
        case (s)
            N_ST:    return N_RT;
            N_RT:    return N_YEL;
            N_YEL:   return E_ST;
            E_ST:    return E_RT;
            E_RT:    return E_YEL;
            E_YEL:   return S_ST;
            S_ST:    return S_RT;
            S_RT:    return S_YEL;
            S_YEL:   return W_ST;
            W_ST:    return W_RT;
            W_RT:    return W_YEL;
            W_YEL:   return PED;
            default: return N_ST;
        endcase
    endfunction

endpackage

// File: rtl/traffic_lights_fsm_lamp_decode.sv
// Maps the registered phase to the four approach lamp vectors; purely combinational, zero latency.
// No flow control: outputs follow the state register directly.
module traffic_lights_fsm_lamp_decode
    import traffic_lights_fsm_pkg::*;
(
    input  state_t     state,
    output logic [7:0] north,
    output logic [7:0] east,
    output logic [7:0] south,
    output logic [7:0] west
);

    always_comb begin
        north = LAMP_IDLE;
        east  = LAMP_IDLE;
        south = LAMP_IDLE;
        west  = LAMP_IDLE;
        case (state)
            N_ST:  north = LAMP_ACT_ST;
            N_RT:  north = LAMP_ACT_RT;
            N_YEL: north = LAMP_ACT_YEL;
            E_ST:  east  = LAMP_ACT_ST;
            E_RT:  east  = LAMP_ACT_RT;
            E_YEL: east  = LAMP_ACT_YEL;
            S_ST:  south = LAMP_ACT_ST;
            S_RT:  south = LAMP_ACT_RT;
            S_YEL: south = LAMP_ACT_YEL;
            W_ST:  west  = LAMP_ACT_ST;
            W_RT:  west  = LAMP_ACT_RT;
            W_YEL: west  = LAMP_ACT_YEL;
            PED: begin
                north = LAMP_PED;
                east  = LAMP_PED;
                south = LAMP_PED;
                west  = LAMP_PED;
            end
            // Unknown codes show all-red; the state register recovers on the next edge.
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_lights_fsm.sv
// Four-way intersection controller: N->E->S->W (straight, right, yellow) then pedestrian phase.
// Moore outputs decoded from the state register; no backpressure, one clock = one second.
module traffic_lights_fsm
    import traffic_lights_fsm_pkg::*;
#(
    parameter int ST_TIME  = 20,
    parameter int RT_TIME  = 10,
    parameter int YEL_TIME = 5,
    parameter int PED_TIME = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    output logic [7:0] north_sgnl_out,
    output logic [7:0] south_sgnl_out,
    output logic [7:0] east_sgnl_out,
    output logic [7:0] west_sgnl_out
);

    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(ST_TIME - 1);
    localparam logic [CNT_W-1:0] RT_LAST  = CNT_W'(RT_TIME - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_TIME - 1);
    localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_TIME - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_st;
    logic [CNT_W-1:0] count_rt;
    logic [CNT_W-1:0] count_yellow;
    logic [CNT_W-1:0] count_st_nxt;
    logic [CNT_W-1:0] count_rt_nxt;
    logic [CNT_W-1:0] count_yellow_nxt;

    // Counters of phases not currently active are forced to zero every cycle.
    always_comb begin
        state_nxt        = state;
        count_st_nxt     = '0;
        count_rt_nxt     = '0;
        count_yellow_nxt = '0;
        case (state)
            N_ST, E_ST, S_ST, W_ST: begin
                if (count_st == ST_LAST) state_nxt = next_state(state);
                else                     count_st_nxt = count_st + 1'b1;
            end
            N_RT, E_RT, S_RT, W_RT: begin
                if (count_rt == RT_LAST) state_nxt = next_state(state);
                else                     count_rt_nxt = count_rt + 1'b1;
            end
            N_YEL, E_YEL, S_YEL, W_YEL: begin
                if (count_yellow == YEL_LAST) state_nxt = next_state(state);
                else                          count_yellow_nxt = count_yellow + 1'b1;
            end
            PED: begin
                if (count_st == PED_LAST) state_nxt = N_ST;
                else                      count_st_nxt = count_st + 1'b1;
            end
            default: state_nxt = N_ST;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= N_ST;
            count_st     <= '0;
            count_rt     <= '0;
            count_yellow <= '0;
        end else begin
            state        <= state_nxt;
            count_st     <= count_st_nxt;
            count_rt     <= count_rt_nxt;
            count_yellow <= count_yellow_nxt;
        end
    end

    traffic_lights_fsm_lamp_decode u_lamp_decode (
        .state (state),
        .north (north_sgnl_out),
        .east  (east_sgnl_out),
        .south (south_sgnl_out),
        .west  (west_sgnl_out)
    );

endmodule

// File: tb/tb_traffic_lights_fsm.sv
// Scoreboarded bench: a timeline model predicts lamps and counters each cycle, a monitor compares at negedge.
module tb_traffic_lights_fsm;

    localparam int T_ST  = 20;
    localparam int T_RT  = 10;
    localparam int T_YEL = 5;
    localparam int T_PED = 15;
    localparam int T_CYC = 4 * (T_ST + T_RT + T_YEL) + T_PED;

    typedef struct packed {
        logic [7:0] n;
        logic [7:0] e;
        logic [7:0] s;
        logic [7:0] w;
        logic [7:0] cst;
        logic [7:0] crt;
        logic [7:0] cy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] north, south, east, west;

    int   checks = 0;
    int   errors = 0;
    int   t      = 0;
    exp_t q[$];

    traffic_lights_fsm dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .north_sgnl_out (north),
        .south_sgnl_out (south),
        .east_sgnl_out  (east),
        .west_sgnl_out  (west)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h (t=%0d)", name, $time, act, req, t);
        end
    endtask

    // Walk the phase timeline from the start of the cycle; seconds left over locate the phase.
    function automatic exp_t model(input int tt);
        exp_t       r;
        logic [7:0] lamp [4];
        int         p     = tt % T_CYC;
        bit         found = 0;
        r.cst = 0; r.crt = 0; r.cy = 0;
        for (int a = 0; a < 4; a++) lamp[a] = 8'h43;
        for (int a = 0; a < 4; a++) begin
            if (!found) begin
                if (p < T_ST) begin lamp[a] = 8'h6A; r.cst = 8'(p); found = 1; end
                else p -= T_ST;
            end
            if (!found) begin
                if (p < T_RT) begin lamp[a] = 8'h71; r.crt = 8'(p); found = 1; end
                else p -= T_RT;
            end
            if (!found) begin
                if (p < T_YEL) begin lamp[a] = 8'h46; r.cy = 8'(p); found = 1; end
                else p -= T_YEL;
            end
        end
        if (!found) begin
            for (int a = 0; a < 4; a++) lamp[a] = 8'h83;
            r.cst = 8'(p);
        end
        r.n = lamp[0]; r.e = lamp[1]; r.s = lamp[2]; r.w = lamp[3];
        return r;
    endfunction

    // One clock: count the edge, optionally assert reset d+1 units after it, optionally release, predict.
    task automatic cycle(input int d, input bit rel);
        @(posedge clk);
        if (rst_n) t++;
        #1;
        if (d >= 0) begin
            #(d);
            rst_n = 1'b0;
            t = 0;
            #(3 - d);
        end else begin
            #3;
        end
        if (rel) rst_n = 1'b1;
        q.push_back(model(t));
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] o [4];
        int         nact;
        bit         pedg;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("north", int'(north), int'(e.n));
            chk("east", int'(east), int'(e.e));
            chk("south", int'(south), int'(e.s));
            chk("west", int'(west), int'(e.w));
            chk("count_st", int'(dut.count_st), int'(e.cst));
            chk("count_rt", int'(dut.count_rt), int'(e.crt));
            chk("count_yellow", int'(dut.count_yellow), int'(e.cy));
        end
        o[0] = north; o[1] = east; o[2] = south; o[3] = west;
        nact = 0;
        pedg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ped_lamp_onehot", int'(o[i][6] ^ o[i][7]), 1);
            chk("st_green_and_red", int'(o[i][3] & o[i][0]), 0);
            if (|{o[i][2], o[i][3], o[i][4], o[i][5]}) nact++;
            if (o[i][7]) pedg = 1'b1;
        end
        chk("single_active_approach", int'(nact <= 1), 1);
        chk("ped_green_exclusive", int'(pedg && nact != 0), 0);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) cycle(-1, 0);
        cycle(-1, 1);
        // Two full rotations plus margin from a clean release.
        repeat (330) cycle(-1, 0);

        // Re-sync, then hit reset asynchronously in the middle of East right-turn (t=58).
        cycle(0, 0);
        cycle(-1, 1);
        repeat (57) cycle(-1, 0);
        cycle(2, 0);
        cycle(-1, 0);
        cycle(-1, 1);
        repeat (60) cycle(-1, 0);

        // Random reset pulses at random points of the rotation.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(5, 200)) cycle(-1, 0);
            cycle(int'($urandom_range(0, 2)), 0);
            repeat ($urandom_range(0, 2)) cycle(-1, 0);
            cycle(-1, 1);
        end
        repeat (40) cycle(-1, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
